// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pwm_ramp_ctrl
// Brief   : Per-channel duty-cycle ramp sequencer sharing one add/subtract
//           unit across channels in an interval-timed round-robin sweep.
//           Optional IRQ status/ports enabled by defining PWM_RAMP_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
    parameter int NUM_CHANNELS = 4,
    parameter int REG_WIDTH    = 16
) (
    input  logic                              i_clk,
    input  logic                              i_resetn,
    input  logic                              i_enable,
    input  logic [NUM_CHANNELS*REG_WIDTH-1:0] i_target,
    input  logic [NUM_CHANNELS-1:0]           i_start,
    input  logic [REG_WIDTH-1:0]              i_step,
    input  logic [REG_WIDTH-1:0]              i_interval,
`ifdef PWM_RAMP_IRQ_EN
    input  logic [NUM_CHANNELS-1:0]           i_irq_clr,
    output logic                              o_irq,
`endif
    output logic [NUM_CHANNELS*REG_WIDTH-1:0] o_duty,
    output logic [NUM_CHANNELS-1:0]           o_busy,
    output logic [NUM_CHANNELS-1:0]           o_done
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    pending;
    logic [REG_WIDTH-1:0]    cnt;
    logic [REG_WIDTH-1:0]    cur [NUM_CHANNELS];
    logic [REG_WIDTH-1:0]    tgt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] busy;
    logic [NUM_CHANNELS-1:0] done;

    logic                    strobe;
    logic [REG_WIDTH-1:0]    sel_cur;
    logic [REG_WIDTH-1:0]    sel_tgt;
    logic [REG_WIDTH-1:0]    stepped;
    logic [REG_WIDTH:0]      diff;
    logic [REG_WIDTH:0]      mag;
    logic                    up;
    logic                    finish;

    assign strobe = (cnt == i_interval);

    // Shared arithmetic for the channel in the current slot; the extra
    // difference bit gives the direction without any overflow.
    always_comb begin
        sel_cur = cur[idx];
        sel_tgt = tgt[idx];
        diff    = {1'b0, sel_tgt} - {1'b0, sel_cur};
        up      = ~diff[REG_WIDTH];
        mag     = up ? diff : -diff;
        finish  = (i_step == '0) || (mag <= {1'b0, i_step});
        stepped = up ? (sel_cur + i_step) : (sel_cur - i_step);
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            cnt     <= '0;
            busy    <= '0;
            done    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cur[c] <= '0;
                tgt[c] <= '0;
            end
        end else if (!i_enable) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            cnt     <= '0;
            busy    <= '0;
            done    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cur[c] <= '0;
            end
        end else begin
            done <= '0;
            cnt  <= strobe ? '0 : cnt + 1'b1;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (i_start[c]) begin
                    tgt[c]  <= i_target[c*REG_WIDTH +: REG_WIDTH];
                    busy[c] <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (strobe || pending) begin
                        state   <= SCAN;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                SCAN: begin
                    if (strobe) begin
                        pending <= 1'b1;
                    end
                    // A start landing on this channel's slot takes priority.
                    if (busy[idx] && !i_start[idx]) begin
                        if (finish) begin
                            cur[idx]  <= sel_tgt;
                            busy[idx] <= 1'b0;
                            done[idx] <= 1'b1;
                        end else begin
                            cur[idx] <= stepped;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    logic [NUM_CHANNELS-1:0] irq_status;
    logic [NUM_CHANNELS-1:0] status_nxt;

    // Set from the done pulse beats a simultaneous write-1-to-clear.
    assign status_nxt = (irq_status & ~i_irq_clr) | done;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            irq_status <= '0;
            o_irq      <= 1'b0;
        end else if (!i_enable) begin
            irq_status <= '0;
            o_irq      <= 1'b0;
        end else begin
            irq_status <= status_nxt;
            o_irq      <= |status_nxt;
        end
    end
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pack
        assign o_duty[c*REG_WIDTH +: REG_WIDTH] = cur[c];
    end

    assign o_busy = busy;
    assign o_done = done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// Bench for pwm_ramp_ctrl: cycle-indexed vector table plus hand sequences for
// the pending sweep path, enable drop, optional IRQ and asynchronous reset.
module tb_pwm_ramp_ctrl;
    localparam int NCH = 4;
    localparam int W   = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable;
    logic [NCH*W-1:0] target;
    logic [NCH-1:0]   start;
    logic [W-1:0]     step;
    logic [W-1:0]     interval;
    logic [NCH*W-1:0] duty;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;
`ifdef PWM_RAMP_IRQ_EN
    logic [NCH-1:0]   irq_clr;
    logic             irq;
`endif

    int checks = 0;
    int errors = 0;
    int now    = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.NUM_CHANNELS(NCH), .REG_WIDTH(W)) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_enable   (enable),
        .i_target   (target),
        .i_start    (start),
        .i_step     (step),
        .i_interval (interval),
`ifdef PWM_RAMP_IRQ_EN
        .i_irq_clr  (irq_clr),
        .o_irq      (irq),
`endif
        .o_duty     (duty),
        .o_busy     (busy),
        .o_done     (done)
    );

    typedef struct {
        int       at;
        int       ch;
        bit       go;
        logic [W-1:0] tgt;
        logic [W-1:0] stp;
        logic [W-1:0] e_duty;
        logic     e_busy;
        logic     e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int at, int ch, bit go, int tgt, int stp,
                                int e_duty, bit e_busy, bit e_done);
        vec_t v;
        v.at = at; v.ch = ch; v.go = go;
        v.tgt = W'(tgt); v.stp = W'(stp); v.e_duty = W'(e_duty);
        v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at now=%0d: got %0d, expected %0d", name, now, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        now++;
        start = '0;
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = '0;
`endif
    endtask

    task automatic resync(input int ival);
        @(negedge clk);
        start    = '0;
        enable   = 1'b0;
        interval = W'(ival);
        @(negedge clk);
        enable = 1'b1;
        now    = 0;
    endtask

    function automatic logic [W-1:0] duty_of(int c);
        logic [NCH*W-1:0] d;
        d = duty;
        return d[c*W +: W];
    endfunction

    initial begin
        resetn = 1'b0; enable = 1'b0; target = '0; start = '0;
        step = '0; interval = 16'd9;
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = '0;
`endif
        // interval 9: slot c of sweep s becomes visible at now = 11 + c + 10*s
        add(0,   0, 1, 350,  100, 0,   0, 0);
        add(1,   0, 0, 0,    0,   0,   1, 0);
        add(10,  0, 0, 0,    0,   0,   1, 0);
        add(11,  0, 0, 0,    0,   100, 1, 0);
        add(21,  0, 0, 0,    0,   200, 1, 0);
        add(31,  0, 0, 0,    0,   300, 1, 0);
        add(41,  0, 0, 0,    0,   350, 0, 1);
        add(41,  1, 1, 350,  0,   0,   0, 0);
        add(42,  0, 0, 0,    0,   350, 0, 0);
        add(51,  1, 0, 0,    0,   0,   1, 0);
        add(52,  1, 1, 0,    200, 350, 0, 1);
        add(62,  1, 0, 0,    0,   150, 1, 0);
        add(72,  1, 1, 999,  0,   0,   0, 1);
        add(82,  1, 0, 0,    0,   999, 0, 1);
        add(82,  2, 1, 1000, 100, 0,   0, 0);
        add(83,  1, 0, 0,    0,   999, 0, 0);
        add(93,  2, 0, 0,    0,   100, 1, 0);
        add(93,  3, 1, 0,    100, 0,   0, 0);
        add(94,  3, 0, 0,    0,   0,   1, 0);
        add(103, 2, 0, 0,    0,   200, 1, 0);
        add(104, 3, 0, 0,    0,   0,   0, 1);
        add(113, 2, 0, 0,    0,   300, 1, 0);
        add(123, 2, 1, 100,  100, 400, 1, 0);
        add(133, 2, 0, 0,    0,   300, 1, 0);
        add(143, 2, 0, 0,    0,   200, 1, 0);
        add(153, 2, 0, 0,    0,   100, 0, 1);
        add(154, 2, 0, 0,    0,   100, 0, 0);
        add(155, 0, 1, 750,  100, 350, 0, 0);
        add(160, 0, 1, 550,  100, 350, 1, 0);
        add(161, 0, 0, 0,    0,   350, 1, 0);
        add(171, 0, 0, 0,    0,   450, 1, 0);
        add(181, 0, 0, 0,    0,   550, 0, 1);

        repeat (3) @(negedge clk);
        chk("reset duty", duty, 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);
`ifdef PWM_RAMP_IRQ_EN
        chk("reset irq", 64'(irq), 0);
`endif
        resetn = 1'b1;

        resync(9);
        foreach (vecs[i]) begin
            while (now < vecs[i].at) tick();
            chk($sformatf("v%0d duty%0d", i, vecs[i].ch), 64'(duty_of(vecs[i].ch)), 64'(vecs[i].e_duty));
            chk($sformatf("v%0d busy%0d", i, vecs[i].ch), 64'(busy[vecs[i].ch]), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d done%0d", i, vecs[i].ch), 64'(done[vecs[i].ch]), 64'(vecs[i].e_done));
            if (vecs[i].go) begin
                start[vecs[i].ch] = 1'b1;
                target[vecs[i].ch*W +: W] = vecs[i].tgt;
                step = vecs[i].stp;
            end
        end

        // Strobe every 2 cycles, sweep needs 5: one update per channel per 5 cycles.
        resync(1);
        step = 16'd100;
        for (int c = 0; c < NCH; c++) target[c*W +: W] = 16'd1000;
        start = '1;
        while (now < 22) begin
            tick();
            for (int c = 0; c < NCH; c++) begin
                int n_upd;
                n_upd = (now >= 3 + c) ? ((now - 3 - c) / 5 + 1) : 0;
                chk($sformatf("pend duty%0d", c), 64'(duty_of(c)), 64'(100 * n_upd));
            end
        end

        enable = 1'b0;
        tick();
        chk("disable duty", duty, 0);
        chk("disable busy", 64'(busy), 0);
        chk("disable done", 64'(done), 0);
        repeat (3) begin
            tick();
            chk("disabled done", 64'(done), 0);
        end

        interval = 16'd9;
        enable   = 1'b1;
        now      = 0;
        target[0*W +: W] = 16'd250;
        start[0] = 1'b1;
        while (now < 11) tick();
        chk("reen duty 1st", duty, 64'd100);
        while (now < 21) tick();
        chk("reen duty 2nd", duty, 64'd200);
        while (now < 31) tick();
        chk("reen duty end", duty, 64'd250);
        chk("reen done", 64'(done), 64'd1);
`ifdef PWM_RAMP_IRQ_EN
        chk("irq before", 64'(irq), 0);
`endif
        tick();
`ifdef PWM_RAMP_IRQ_EN
        chk("irq set", 64'(irq), 1);
`endif
        target[3*W +: W] = 16'd0;
        start[3] = 1'b1;
        while (now < 34) tick();
        chk("ch3 done", 64'(done), 64'd8);
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = 4'b1001;
`endif
        tick();
`ifdef PWM_RAMP_IRQ_EN
        chk("irq set wins", 64'(irq), 1);
        irq_clr = 4'b1000;
`endif
        tick();
`ifdef PWM_RAMP_IRQ_EN
        chk("irq cleared", 64'(irq), 0);
`endif

        target[1*W +: W] = 16'd500;
        start[1] = 1'b1;
        while (now < 42) tick();
        chk("pre-reset duty1", 64'(duty_of(1)), 64'd100);
        chk("pre-reset busy", 64'(busy), 64'd2);
        #2 resetn = 1'b0;
        #1;
        chk("async duty", duty, 0);
        chk("async busy", 64'(busy), 0);
        #2 resetn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Per-channel duty-cycle ramp sequencer that sits between the register file and the multi-channel PWM core. It slews each channel's duty value from its current level to a software-written target in fixed steps at a programmable interval, giving soft-start and soft-stop without CPU involvement. A single shared add/subtract unit serves all channels through a round-robin sweep started by an interval timer.

## Interface
- NUM_CHANNELS, 4, number of ramped channels (1..16)
- REG_WIDTH, 16, width of duty, target, step and interval values
- i_clk  in  1  system clock
- i_resetn  in  1  reset, asynchronous, active-low
- i_enable  in  1  global enable; low = synchronous clear of all ramp state
- i_target  in  NUM_CHANNELS*REG_WIDTH  target duty; channel c at [c*REG_WIDTH +: REG_WIDTH]
- i_start  in  NUM_CHANNELS  per-channel one-cycle pulse: latch target, begin ramp
- i_step  in  REG_WIDTH  duty increment/decrement per update; 0 = jump directly to target
- i_interval  in  REG_WIDTH  sweep period minus 1, in i_clk cycles
- o_duty  out  NUM_CHANNELS*REG_WIDTH  current duty to PWM core, same packing as i_target
- o_busy  out  NUM_CHANNELS  channel ramp in progress
- o_done  out  NUM_CHANNELS  one-cycle pulse when channel reaches its target

## Operation
- Per channel registers: cur (drives o_duty), tgt (latched target), busy.
- i_start[c]: tgt[c] <= i_target[c], busy[c] <= 1; cur unchanged. Restart while busy re-latches target and continues from current cur. i_target changes without i_start are ignored.
- Interval timer: cnt counts 0..i_interval, wraps to 0; strobe when cnt == i_interval.
- FSM states: IDLE, SCAN.
  - IDLE: on strobe (or pending flag) -> SCAN, idx <= 0, pending cleared.
  - SCAN: one channel per cycle, idx 0..NUM_CHANNELS-1; after last idx -> IDLE.
  - Strobe during SCAN sets pending (single bit, not a counter); extra strobes while pending are dropped.
- Slot processing for channel idx with busy=1 (shared unit, REG_WIDTH+1-bit difference, no overflow):
  - diff = |tgt - cur|; if i_step == 0 or diff <= i_step: cur <= tgt, busy <= 0, o_done pulse.
  - else cur <= cur + i_step if tgt > cur, cur - i_step if tgt < cur.
  - busy=0: no change.
- Start with tgt == cur: busy set; completes (o_done) at next slot for that channel.
- i_start[c] in the same cycle as channel c's slot: start wins, no step applied this sweep.
- i_enable low: cnt <= 0, FSM -> IDLE, pending/busy/o_done cleared, cur cleared to 0 (outputs drive 0% duty). tgt retained.

## Timing
- Reset values: o_duty 0, o_busy 0, o_done 0, o_irq 0 (when present); cnt 0, FSM IDLE, pending 0, tgt 0.
- First strobe i_interval+1 cycles after i_enable rises; subsequent strobes every i_interval+1 cycles.
- Channel c updated on the clock edge c+1 cycles after the strobe cycle (IDLE->SCAN takes one cycle; slot c occupies SCAN cycle c).
- o_done[c] and busy clear registered on the same edge as the final cur update.
- i_interval+1 < NUM_CHANNELS+1: sweeps run back-to-back via pending; effective update rate one sweep per NUM_CHANNELS+1 cycles.
- i_step, i_interval sampled live; changes take effect at next slot / next compare.
- Async reset mid-sweep: all state to reset values immediately.

## Configuration
- PWM_RAMP_IRQ_EN defined: adds ports i_irq_clr (in, NUM_CHANNELS, write-1-to-clear pulses) and o_irq (out, 1). Per-channel sticky status bit set on o_done[c]; o_irq = OR of status bits, registered; set wins over simultaneous clear; i_enable low clears status.
- Not defined: ports and status logic absent; completion visible only via o_done/o_busy.

## Test plan
- Up-ramp: i_interval=9, i_step=100, start ch0 target 350 from 0 -> o_duty0 100,200,300,350 at 10-cycle spacing; o_done[0] pulse with the 350 update; o_busy[0] low after.
- Down-ramp and step 0: ch1 cur=350, target 0 step 200 -> 150, 0; then i_step=0 target 999 -> 999 on first slot.
- All channels, i_interval=1 (strobe faster than sweep) -> pending path: one update per channel per 5 cycles, no skipped or duplicated slots.
- Restart mid-ramp: ch2 ramping to 1000 at 400, i_start with target 100 -> next value 300, continues down to 100, single o_done.
- i_enable dropped mid-ramp -> next cycle o_duty all 0, o_busy 0, no o_done; re-enable with fresh i_start ramps from 0.
- PWM_RAMP_IRQ_EN: done on ch3 -> o_irq 1 next cycle; i_irq_clr[3] coincident with new done keeps o_irq high; clear alone drops it.
